// File: rtl/lcv_div_iter.sv
// lcv_div_iter: iterative radix-2 restoring divider for the execute-stage divide unit.
// Resolves one quotient bit per cycle. Valid/ready on both sides, one operation in flight.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   operand handshake (dividend, divisor, is_signed)
//   out_valid/out_ready result handshake (quot, rem)
//   quot                quotient, truncated toward zero
//   rem                 remainder, same sign as the dividend
//
// Configuration macro LCV_DIV_ITER_SIGNED_EN:
//   defined   - is_signed is honoured, with magnitude/negation logic and MIN/-1 overflow detect
//   undefined - is_signed is ignored and every operation is unsigned
module lcv_div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q_wk;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             ovf;
    logic             div_zero;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   acc_sel;
    logic             no_borrow;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] q_nx;
    logic             unused_bits;

    assign accept   = in_valid & in_ready;
    assign div_zero = (divisor == '0);

    // Sign handling: only built when signed operation is enabled
`ifdef LCV_DIV_ITER_SIGNED_EN
    assign dvd_neg     = is_signed & dividend[WIDTH-1];
    assign dvs_neg     = is_signed & divisor[WIDTH-1];
    assign ovf         = is_signed & (dividend == MIN_VAL) & (divisor == '1);
    assign unused_bits = acc_sel[WIDTH];
`else
    assign dvd_neg     = 1'b0;
    assign dvs_neg     = 1'b0;
    assign ovf         = 1'b0;
    assign unused_bits = ^{is_signed, acc_sel[WIDTH]};
`endif

    // |MIN| is 2^(WIDTH-1), which still fits WIDTH bits when read as unsigned
    assign dvd_mag = dvd_neg ? WIDTH'(-dividend) : dividend;
    assign dvs_mag = dvs_neg ? WIDTH'(-divisor)  : divisor;

    // One restoring step: the shifted partial remainder needs WIDTH+1 bits
    assign shifted   = {acc, q_wk[WIDTH-1]};
    assign no_borrow = (shifted >= {1'b0, dvs});
    assign diff      = shifted - {1'b0, dvs};
    assign acc_sel   = no_borrow ? diff : shifted;
    assign acc_nx    = acc_sel[WIDTH-1:0];
    assign q_nx      = {q_wk[WIDTH-2:0], no_borrow};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = (div_zero || ovf) ? DONE : RUN;
            RUN:     if (cnt == CW'(1)) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
        end
    end

    // Datapath: operand latch, iteration, sign fixup on the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            acc   <= '0;
            q_wk  <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            quot  <= '0;
            rem   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            quot <= '1;
                            rem  <= dividend;
                        end else if (ovf) begin
                            quot <= MIN_VAL;
                            rem  <= '0;
                        end else begin
                            acc   <= '0;
                            q_wk  <= dvd_mag;
                            dvs   <= dvs_mag;
                            neg_q <= dvd_neg ^ dvs_neg;
                            neg_r <= dvd_neg;
                            cnt   <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    acc  <= acc_nx;
                    q_wk <= q_nx;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quot <= neg_q ? WIDTH'(-q_nx)   : q_nx;
                        rem  <= neg_r ? WIDTH'(-acc_nx) : acc_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
